// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared FSM/step types, Gray positions and settle constant for quad_decoder
package quad_pkg;

  typedef enum logic {INIT, TRACK} quad_state_t;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_UP,
    STEP_DOWN,
    STEP_ERR
  } quad_step_t;

  // {A,B} Gray positions; A leads B when counting up
  localparam logic [1:0] POS_00 = 2'b00;
  localparam logic [1:0] POS_10 = 2'b10;
  localparam logic [1:0] POS_11 = 2'b11;
  localparam logic [1:0] POS_01 = 2'b01;

  // INIT must outlast the synchroniser plus the filter so prev holds the settled position
  function automatic int settle_cycles(input int debounce_cycles, input bit filter_en);
    return filter_en ? debounce_cycles + 3 : 3;
  endfunction

  function automatic quad_step_t classify_step(input logic [1:0] prev, input logic [1:0] cur);
    quad_step_t step;
    step = STEP_NONE;
    if ((prev ^ cur) == 2'b11) begin
      step = STEP_ERR;
    end else if (prev != cur) begin
      case (prev)
        POS_00:  step = (cur == POS_10) ? STEP_UP : STEP_DOWN;
        POS_10:  step = (cur == POS_11) ? STEP_UP : STEP_DOWN;
        POS_11:  step = (cur == POS_01) ? STEP_UP : STEP_DOWN;
        default: step = (cur == POS_00) ? STEP_UP : STEP_DOWN;
      endcase
    end
    return step;
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// rtl/quad_debounce.sv - one-bit level filter: output follows input after DEBOUNCE_CYCLES stable cycles
module quad_debounce
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic clk50m,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // any sample that agrees with the output restarts the run, so short glitches never land
  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dout  <= 1'b0;
    end else if (din == dout) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_LAST) begin
      dout  <= din;
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - x4 quadrature decoder driving counter en/up_dn_n; filter enabled by QUAD_DEBOUNCE_EN
module quad_decoder
  import quad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500
) (
  input  logic rst_n,
  input  logic clk50m,
  input  logic enc_a,
  input  logic enc_b,
  output logic en,
  output logic up_dn_n,
  output logic err
);

`ifdef QUAD_DEBOUNCE_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  localparam int SETTLE = settle_cycles(DEBOUNCE_CYCLES, FILTER_EN);
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  logic        a_meta, a_s;
  logic        b_meta, b_s;
  logic [1:0]  cur;

  quad_state_t state_q, state_d;
  logic [SW-1:0] settle_q, settle_d;
  logic [1:0]  prev_q, prev_d;
  logic        en_d, dir_d, err_d;
  quad_step_t  step;

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      a_meta <= 1'b0;
      a_s    <= 1'b0;
      b_meta <= 1'b0;
      b_s    <= 1'b0;
    end else begin
      a_meta <= enc_a;
      a_s    <= a_meta;
      b_meta <= enc_b;
      b_s    <= b_meta;
    end
  end

`ifdef QUAD_DEBOUNCE_EN
  logic a_f, b_f;

  quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .din    (a_s),
    .dout   (a_f)
  );

  quad_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk50m (clk50m),
    .rst_n  (rst_n),
    .din    (b_s),
    .dout   (b_f)
  );

  assign cur = {a_f, b_f};
`else
  assign cur = {a_s, b_s};
`endif

  always_ff @(posedge clk50m) begin
    if (!rst_n) begin
      state_q  <= INIT;
      settle_q <= '0;
      prev_q   <= POS_00;
      en       <= 1'b0;
      up_dn_n  <= 1'b1;
      err      <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      prev_q   <= prev_d;
      en       <= en_d;
      up_dn_n  <= dir_d;
      err      <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    prev_d   = prev_q;
    en_d     = 1'b0;
    dir_d    = up_dn_n;
    err_d    = 1'b0;
    step     = STEP_NONE;
    case (state_q)
      INIT: begin
        // absorb whatever position the encoder rests at, so power-up never reports a step
        prev_d = cur;
        if (settle_q == SETTLE_LAST) begin
          state_d  = TRACK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      default: begin
        prev_d = cur;
        step   = classify_step(prev_q, cur);
        case (step)
          STEP_UP: begin
            en_d  = 1'b1;
            dir_d = 1'b1;
          end
          STEP_DOWN: begin
            en_d  = 1'b1;
            dir_d = 1'b0;
          end
          STEP_ERR: err_d = 1'b1;
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_quad_decoder.sv
// tb/tb_quad_decoder.sv - scoreboard bench for quad_decoder (default and QUAD_DEBOUNCE_EN builds)
module tb_quad_decoder;

  localparam int DC = 4;
`ifdef QUAD_DEBOUNCE_EN
  localparam int LAT    = DC + 3;
  localparam int SETTLE = DC + 3;
`else
  localparam int LAT    = 3;
  localparam int SETTLE = 3;
`endif

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_UP   = 2'd1;
  localparam logic [1:0] K_DN   = 2'd2;
  localparam logic [1:0] K_ERR  = 2'd3;

  // {a, b, expected kind}
  localparam logic [3:0] UP_TAB [4] = '{4'b10_01, 4'b11_01, 4'b01_01, 4'b00_01};
  localparam logic [3:0] DN_TAB [4] = '{4'b01_10, 4'b11_10, 4'b10_10, 4'b00_10};
  localparam logic [3:0] ER_TAB [2] = '{4'b11_11, 4'b00_11};

  typedef struct {
    logic is_err;
    logic dir;
    int   due;
  } ev_t;

  logic clk50m = 1'b0;
  logic rst_n  = 1'b0;
  logic enc_a  = 1'b0;
  logic enc_b  = 1'b0;
  logic en, up_dn_n, err;

  ev_t  exp_q[$];
  int   cyc     = 0;
  int   n_vec   = 0;
  int   n_bad   = 0;
  int   pos     = 0;
  logic exp_dir = 1'b1;

  quad_decoder #(.DEBOUNCE_CYCLES(DC)) dut (
    .rst_n   (rst_n),
    .clk50m  (clk50m),
    .enc_a   (enc_a),
    .enc_b   (enc_b),
    .en      (en),
    .up_dn_n (up_dn_n),
    .err     (err)
  );

  always #10 clk50m = ~clk50m;

  always @(posedge clk50m) cyc <= cyc + 1;

  always @(negedge clk50m) begin : monitor
    ev_t e;
    while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
      n_vec++;
      n_bad++;
      $display("FAIL missed_event: expected at cycle %0d, nothing seen by cycle %0d", exp_q[0].due, cyc);
      void'(exp_q.pop_front());
    end
    if (en || err) begin
      n_vec++;
      if (en && err) begin
        n_bad++;
        $display("FAIL en_err_overlap: en=%b err=%b at cycle %0d, required not both high", en, err, cyc);
      end else if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_event: en=%b err=%b up_dn_n=%b at cycle %0d, required none", en, err, up_dn_n, cyc);
      end else begin
        e = exp_q.pop_front();
        if (err !== e.is_err || up_dn_n !== e.dir || cyc != e.due) begin
          n_bad++;
          $display("FAIL event: got err=%b up_dn_n=%b cycle=%0d, required err=%b up_dn_n=%b cycle=%0d",
                   err, up_dn_n, cyc, e.is_err, e.dir, e.due);
        end
      end
      if (en && !err) pos = up_dn_n ? pos + 1 : pos - 1;
    end
  end

  task automatic check_bit(input string name, input logic act, input logic req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic push_ev(input logic [1:0] kind);
    ev_t e;
    if (kind == K_UP) exp_dir = 1'b1;
    if (kind == K_DN) exp_dir = 1'b0;
    e.is_err = (kind == K_ERR);
    e.dir    = exp_dir;
    e.due    = cyc + LAT;
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [3:0] v, input int hold);
    logic [3:0] t;
    t = v;
    @(negedge clk50m);
    enc_a = t[3];
    enc_b = t[2];
    if (t[1:0] != K_NONE) push_ev(t[1:0]);
    repeat (hold - 1) @(negedge clk50m);
  endtask

  task automatic check_idle(input string name);
    check_bit({name, "_en"}, en, 1'b0);
    check_bit({name, "_err"}, err, 1'b0);
    check_bit({name, "_up_dn_n"}, up_dn_n, 1'b1);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    // reset with the encoder resting at 11: INIT must absorb it
    enc_a = 1'b1;
    enc_b = 1'b1;
    repeat (4) @(negedge clk50m);
    check_idle("reset_11");
    rst_n = 1'b1;
    repeat (SETTLE + 15) @(negedge clk50m);
    check_idle("idle_11");

    // second reset at 00; first step lands as early as TRACK allows
    rst_n = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    repeat (3) @(negedge clk50m);
    check_idle("reset_00");
    rst_n = 1'b1;
    repeat (SETTLE - 3) @(negedge clk50m);

    for (int i = 0; i < 4; i++) apply(UP_TAB[i], 20);
    check_int("count_after_up", pos, 4);

    for (int i = 0; i < 3; i++) apply(DN_TAB[i], 20);
    check_int("count_after_3_down", pos, 1);
    apply(DN_TAB[3], 20);
    check_int("count_after_wrap_down", pos, 0);
    check_bit("dir_after_down", up_dn_n, 1'b0);

    // 2-cycle glitch on A: filtered build rejects it, raw build sees up then down
    @(negedge clk50m);
    enc_a = 1'b1;
`ifndef QUAD_DEBOUNCE_EN
    push_ev(K_UP);
`endif
    repeat (2) @(negedge clk50m);
    enc_a = 1'b0;
`ifndef QUAD_DEBOUNCE_EN
    push_ev(K_DN);
`endif
    repeat (20) @(negedge clk50m);
    check_int("count_after_glitch", pos, 0);

    for (int i = 0; i < 2; i++) apply(ER_TAB[i], 20);
    check_int("count_after_err", pos, 0);
    check_bit("dir_kept_after_err", up_dn_n, 1'b0);

    // reset while a step is still in flight: it must never be reported
    @(negedge clk50m);
    enc_a = 1'b1;
    @(negedge clk50m);
    rst_n = 1'b0;
    @(negedge clk50m);
    check_idle("reset_midstep");
    repeat (3) @(negedge clk50m);
    rst_n = 1'b1;
    repeat (SETTLE + 30) @(negedge clk50m);
    check_idle("after_midstep_reset");
    check_int("count_final", pos, 0);
    check_int("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/quad_decoder.md
# quad_decoder

Quadrature (rotary encoder) front end that turns two asynchronous encoder channels into the step/direction controls of the up/down counter. It sits directly upstream of that counter and drives its `en` and `up_dn_n` inputs as a one-cycle step pulse plus a direction level. Internally it synchronises both channels, optionally debounces them, and decodes legal Gray-code steps in x4 mode. Illegal double transitions are flagged on `err`.

## Interface
- `DEBOUNCE_CYCLES`, default 500: consecutive stable cycles required before a filtered channel changes. The legal range is 1 to 2^20.
- `rst_n`  in  1  synchronous, active-low reset, sampled on `posedge clk50m`.
- `clk50m`  in  1  50 MHz system clock; all flops run on its rising edge.
- `enc_a`  in  1  encoder channel A; asynchronous.
- `enc_b`  in  1  encoder channel B; asynchronous.
- `en`  out  1  one-cycle step pulse; connects to the counter's `en`.
- `up_dn_n`  out  1  direction of the last step (1 = up, 0 = down); connects to the counter's `up_dn_n`.
- `err`  out  1  one-cycle pulse on an illegal transition (both channels changed).

## Operation
- **Synchroniser.** Two flops per channel produce `a_s`/`b_s`. Both reset to 0.
- **Debounce filter** (see Configuration). Each channel has a counter of width $clog2(DEBOUNCE_CYCLES+1).
  - If the raw sample equals the filtered value, the counter clears.
  - Otherwise the counter increments.
  - When the counter would reach `DEBOUNCE_CYCLES`, the filtered value takes the raw sample and the counter clears.
  - The filtered value and counter reset to 0.
- **Decoder FSM**, two states: `INIT` and `TRACK`. Register `prev[1:0]` holds {A,B}.
  - **INIT** (reset state):
    - Loads `prev` from the filtered {A,B} every cycle.
    - Holds `en` = `err` = 0.
    - A settle counter runs SETTLE = `DEBOUNCE_CYCLES`+3 cycles (3 when the filter is compiled out), then moves to TRACK.
  - **TRACK**: compares the current filtered value `cur` with `prev` every cycle, then loads `prev` <= `cur`.
    - **Up sequence:** 00 -> 10 -> 11 -> 01 -> 00. A leads B.
    - **Down sequence:** 00 -> 01 -> 11 -> 10 -> 00.
    - **Legal up step:** `en`=1, `up_dn_n`=1 for the next cycle.
    - **Legal down step:** `en`=1, `up_dn_n`=0 for the next cycle.
    - **cur == prev:** `en`=0 and `up_dn_n` holds.
    - **Both bits differ:** `err`=1, `en`=0, `up_dn_n` holds, and `prev` still updates (resynchronise).
  - TRACK never returns to INIT except through reset.
- **Reset values:** `en`=0, `up_dn_n`=1, `err`=0, state INIT, `prev`=00, settle counter 0, all synchroniser and filter flops 0.
- **Reset mid-operation:** every register takes its reset value at the next rising edge with `rst_n`=0. A pending step is dropped and no `en` is produced for it.
- **Wrap-around:** 01 -> 00 (up) and 10 -> 00 (down) are ordinary steps. The decoder has no position limit, so counting range is the downstream counter's concern.
- `en` and `err` are never high in the same cycle.

## Timing
- All outputs are registered; there is no combinational path from input to output.
- **Latency with filter:** a clean level change on one channel, captured at edge k, produces `en` high during the cycle after edge k+2+`DEBOUNCE_CYCLES`.
- **Latency without filter:** `en` is high in the cycle after edge k+2.
- **Throughput:** one step per clock at most. Consecutive legal steps on consecutive filtered changes give back-to-back `en` pulses.
- **Glitch rejection:** a raw pulse shorter than `DEBOUNCE_CYCLES` cycles after synchronisation never changes the filtered value.

## Configuration
- **`QUAD_DEBOUNCE_EN`:**
  - **Defined:** the debounce filter is instantiated per channel, SETTLE = `DEBOUNCE_CYCLES`+3, and latency is as stated above.
  - **Not defined:** the filter is removed, `cur` = {`a_s`,`b_s`}, `DEBOUNCE_CYCLES` is ignored, and SETTLE = 3.
- The macro is off by default in simulation filelists and defined in the board build.

## Structure
- **Package `quad_pkg`:**
  - `typedef enum logic {INIT, TRACK} quad_state_t`
  - the `localparam` encodings of the four Gray positions
  - the SETTLE computation as a constant function
- **Sub-module `quad_debounce`:** a one-bit filter with parameter `DEBOUNCE_CYCLES` and ports `clk50m`, `rst_n`, `din`, `dout`. It is instantiated twice, inside the `QUAD_DEBOUNCE_EN` guard.
- `quad_decoder` holds the synchronisers, the FSM, `prev` and the output registers.

## Test plan
- **Reset and idle:** reset, hold `enc_a`=`enc_b`=0, release -> `en`=0, `err`=0, `up_dn_n`=1 throughout. The FSM reaches TRACK after SETTLE cycles.
- **Idle inputs at 11 during reset:** release reset with both inputs at 11 -> no `err` and no `en`, because INIT absorbs the initial position.
- **Four up steps:** `DEBOUNCE_CYCLES`=4, drive 00 -> 10 -> 11 -> 01 -> 00, each held 20 cycles -> exactly 4 `en` pulses with `up_dn_n`=1. The downstream counter reads 4. The first pulse arrives 7 cycles after the edge.
- **Three down steps:** from 00, drive 01 -> 11 -> 10 -> 4 `en` pulses? No: exactly 3 `en` pulses with `up_dn_n`=0. The counter steps from 4 to 1.
- **Glitch and illegal jump:** a 2-cycle glitch on `enc_a` with `DEBOUNCE_CYCLES`=4 -> no `en` and no `err`. A simultaneous 00 -> 11 jump -> a single `err` pulse, no `en`, and `up_dn_n` unchanged.
- **Reset mid-debounce:** assert `rst_n`=0 mid-debounce while a step is pending -> all outputs return to reset values on the next edge and the step is never reported.
